// File: rtl/ex_alu_unit.sv
// ---------------------------------------------------------------------------
// ex_alu_unit
// Execute-stage ALU that sits behind the operand-select mux. Operand A comes
// straight from the register file; operand B is already the rs2/immediate
// choice. The result is registered and handed downstream with a valid/ready
// handshake. Single-cycle integer ops finish one edge after acceptance.
// MUL/MULHU run on an iterative shift-add engine that takes 32 edges.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    upstream presents an operation
//   in_ready    unit accepts the operation this cycle
//   Read1       operand A (rs1 value)
//   Read2       operand B (rs2 or immediate)
//   ALUop       operation code (0..11 legal, 12..15 give result 0)
//   rd_in       destination register tag
//   out_valid   ALU_result / rd_out / Zero are valid
//   out_ready   downstream consumes the result this cycle
//   ALU_result  registered result
//   rd_out      tag travelling with the result
//   Zero        1 when ALU_result == 0
//
// State  | meaning
// -------+-----------------------------------------------
// IDLE   | no result held, ready for a new operation
// BUSY   | multiply iterating on latched operands
// DONE   | result held until downstream takes it
// ---------------------------------------------------------------------------
module ex_alu_unit #(
   parameter bit          MUL_ENABLE = 1'b1,
   parameter int unsigned MUL_STEPS  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] Read1,
   input  logic [31:0] Read2,
   input  logic [3:0]  ALUop,
   input  logic [4:0]  rd_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] ALU_result,
   output logic [4:0]  rd_out,
   output logic        Zero
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;

   // Counter value seen on the edge that processes the last multiplier bit.
   localparam logic [5:0] CNT_LAST = 6'(MUL_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_q, rd_d;
   logic        zero_q, zero_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic        mul_hi_q, mul_hi_d;
   logic [4:0]  mul_rd_q, mul_rd_d;

   logic [31:0] alu_res;
   logic [4:0]  shamt;
   logic        is_mul_op;
   logic        accept;
   logic [63:0] acc_step;

   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state_q == ST_DONE);
   assign ALU_result = result_q;
   assign rd_out     = rd_q;
   assign Zero       = zero_q;

   // Only routed to the iterative engine when it is actually built; otherwise
   // the multiply opcodes fall through the single-cycle path with result 0.
   assign is_mul_op = MUL_ENABLE && ((ALUop == OP_MUL) || (ALUop == OP_MULHU));

   // One shift-add step: multiplier is consumed LSB first while the
   // multiplicand walks left, so the accumulator never needs a shifter.
   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      shamt   = Read2[4:0];
      alu_res = '0;
      case (ALUop)
         OP_ADD:  alu_res = Read1 + Read2;
         OP_SUB:  alu_res = Read1 - Read2;
         OP_AND:  alu_res = Read1 & Read2;
         OP_OR:   alu_res = Read1 | Read2;
         OP_XOR:  alu_res = Read1 ^ Read2;
         OP_SLL:  alu_res = Read1 << shamt;
         OP_SRL:  alu_res = Read1 >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(Read1) >>> shamt);
         OP_SLT:  alu_res = {31'd0, ($signed(Read1) < $signed(Read2))};
         OP_SLTU: alu_res = {31'd0, (Read1 < Read2)};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rd_d     = rd_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      mul_hi_d = mul_hi_q;
      mul_rd_d = mul_rd_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == CNT_LAST) begin
               result_d = mul_hi_q ? acc_step[63:32] : acc_step[31:0];
               zero_d   = mul_hi_q ? (acc_step[63:32] == 32'd0)
                                   : (acc_step[31:0] == 32'd0);
               rd_d     = mul_rd_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Acceptance can only happen in IDLE or in DONE while the held result
      // is being consumed, so it safely overrides the per-state defaults.
      if (accept) begin
         if (is_mul_op) begin
            state_d  = ST_BUSY;
            acc_d    = '0;
            cnt_d    = '0;
            mcand_d  = {32'd0, Read1};
            mplier_d = Read2;
            mul_hi_d = (ALUop == OP_MULHU);
            mul_rd_d = rd_in;
         end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
            rd_d     = rd_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         rd_q     <= '0;
         zero_q   <= 1'b1;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mul_hi_q <= 1'b0;
         mul_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         zero_q   <= zero_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         mul_hi_q <= mul_hi_d;
         mul_rd_q <= mul_rd_d;
      end
   end

endmodule

// File: tb/tb_ex_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_unit
// Scoreboard bench for ex_alu_unit. The driver pushes the reference result
// for every accepted operation; an independent monitor pops and compares
// whenever a result is handed downstream. Directed cases cover reset, the
// shifts/compares, multiply latency, backpressure, back-to-back throughput
// and reset while a multiply is in flight; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ex_alu_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] Read1 = '0;
   logic [31:0] Read2 = '0;
   logic [3:0]  ALUop = '0;
   logic [4:0]  rd_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ALU_result;
   logic [4:0]  rd_out;
   logic        Zero;

   ex_alu_unit dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Read1      (Read1),
      .Read2      (Read2),
      .ALUop      (ALUop),
      .rd_in      (rd_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALU_result (ALU_result),
      .rd_out     (rd_out),
      .Zero       (Zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   rand_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: operation semantics written directly from the opcode table.
   function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] prod;
      int          sh;
      prod = {32'd0, a} * {32'd0, b};
      sh   = int'(b[4:0]);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return $unsigned($signed(a) >>> sh);
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd10:   return prod[31:0];
         4'd11:   return prod[63:32];
         default: return 32'd0;
      endcase
   endfunction

   // Drive one operation and wait (bounded) for its acceptance edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int acc_cyc);
      int   waited;
      bit   done;
      exp_t e;
      if (clk == 1'b0) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      ALUop    = op;
      Read1    = a;
      Read2    = b;
      rd_in    = rd;
      waited   = 0;
      done     = 1'b0;
      acc_cyc  = -1;
      while (!done && waited < 300) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(posedge clk);
            waited++;
         end
      end
      if (done) begin
         e.res = ref_model(op, a, b);
         e.rd  = rd;
         sb.push_back(e);
      end else begin
         n_chk++;
         $display("FAIL accept_timeout: op %0d not accepted within 300 cycles", op);
      end
      #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   // Monitor: compares every handed-off result and checks hold stability.
   logic        hold = 1'b0;
   logic [31:0] h_res;
   logic [4:0]  h_rd;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid",  32'(out_valid), 32'd1);
            check("hold_result", ALU_result, h_res);
            check("hold_rd",     32'(rd_out), 32'(h_rd));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_output: result 0x%08h rd %0d with empty scoreboard",
                        ALU_result, rd_out);
            end else begin
               e = sb.pop_front();
               check("result", ALU_result, e.res);
               check("rd_tag", 32'(rd_out), 32'(e.rd));
               check("zero",   32'(Zero), (e.res == 32'd0) ? 32'd1 : 32'd0);
            end
         end
         hold  = out_valid && !out_ready;
         h_res = ALU_result;
         h_rd  = rd_out;
      end
   end

   initial begin
      int c1, c2, c3;
      logic [3:0]  op;
      logic [31:0] a, b;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_result", ALU_result, 32'd0);
      check("rst_rd",     32'(rd_out), 32'd0);
      check("rst_zero",   32'(Zero), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // ADD wrapping to zero, latency 1.
      issue(4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 5'd3, c1);
      @(negedge clk);
      check("add_latency_valid", 32'(out_valid), 32'd1);

      issue(4'd7, 32'h8000_0000, 32'h0000_0024, 5'd4, c1);
      issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, c1);
      issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, c1);

      // MUL and MULHU: 32 busy cycles, result on the 33rd.
      for (int m = 0; m < 2; m++) begin
         issue((m == 0) ? 4'd10 : 4'd11, 32'hFFFF_FFFF, 32'h0000_0002, 5'(7 + m), c1);
         for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("mul_busy_ready", 32'(in_ready), 32'd0);
            check("mul_busy_valid", 32'(out_valid), 32'd0);
         end
         @(negedge clk);
         check("mul_done_valid", 32'(out_valid), 32'd1);
      end

      // Backpressure on an OR result with junk inputs presented meanwhile.
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(4'd3, 32'h0F0F_0000, 32'h0000_F0F0, 5'd9, c1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid",  32'(out_valid), 32'd1);
         check("bp_result", ALU_result, 32'h0F0F_F0F0);
         check("bp_rd",     32'(rd_out), 32'd9);
         check("bp_ready",  32'(in_ready), 32'd0);
         in_valid = 1'b1;
         ALUop    = 4'($urandom_range(0, 9));
         Read1    = $urandom;
         Read2    = $urandom;
         rd_in    = 5'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      issue(4'd0, 32'd1, 32'd2, 5'd10, c1);

      // Back-to-back stream, one op per cycle.
      issue(4'd0, 32'h1234_5678, 32'h1111_1111, 5'd11, c1);
      issue(4'd1, 32'h0000_0010, 32'h0000_0020, 5'd12, c2);
      issue(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd13, c3);
      check("b2b_gap1", 32'(c2 - c1), 32'd1);
      check("b2b_gap2", 32'(c3 - c2), 32'd1);

      // Reset in the middle of a multiply.
      issue(4'd10, 32'hDEAD_BEEF, 32'h0000_1234, 5'd14, c1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mrst_valid",  32'(out_valid), 32'd0);
      check("mrst_result", ALU_result, 32'd0);
      check("mrst_zero",   32'(Zero), 32'd1);
      check("mrst_rd",     32'(rd_out), 32'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check("mrst_hold_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(4'd0, 32'd40, 32'd2, 5'd15, c1);
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd1);

      // Randomized phase with random downstream backpressure.
      @(posedge clk);
      #1 rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 120; i++) begin
               op = 4'($urandom_range(0, 15));
               case ($urandom_range(0, 5))
                  0:       a = 32'd0;
                  1:       a = 32'hFFFF_FFFF;
                  2:       a = 32'h8000_0000;
                  default: a = $urandom;
               endcase
               case ($urandom_range(0, 5))
                  0:       b = 32'd0;
                  1:       b = 32'hFFFF_FFFF;
                  2:       b = 32'($urandom_range(0, 31));
                  default: b = $urandom;
               endcase
               issue(op, a, b, 5'($urandom), c1);
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      check("drain_empty", 32'(sb.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage consumer of the ALU operand-select mux output.
- Takes operand A (Read1) and the already-selected operand B (Read2, either RS2_full or IMM_full) and produces a registered result with a valid/ready handshake.
- Single-cycle integer ops complete in 1 cycle; MUL/MULHU use an iterative 32-step shift-add engine.
- Feeds the EX/MEM register and the writeback path.

Parameters:
- MUL_ENABLE, 1, 1 = iterative multiplier present; 0 = MUL/MULHU complete in 1 cycle with result 0.
- MUL_STEPS, 32, number of multiply iterations; fixed at 32 for the 32-bit datapath.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit accepts the operation this cycle
- Read1  input  32  operand A (rs1 value)
- Read2  input  32  operand B from the operand-select mux (rs2 or immediate)
- ALUop  input  4  operation code
- rd_in  input  5  destination register tag
- out_valid  output  1  ALU_result/rd_out/Zero are valid
- out_ready  input  1  downstream consumes the result this cycle
- ALU_result  output  32  registered result
- rd_out  output  5  tag travelling with the result
- Zero  output  1  1 when ALU_result == 0

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, out_valid=0, ALU_result=0, rd_out=0, Zero=1, iteration counter=0, internal accumulators=0.
- ALUop encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = Read2[4:0].
  - 8 SLT (signed), 9 SLTU; result 1 or 0, zero-extended.
  - 10 MUL = low 32 bits of the unsigned 64-bit product; 11 MULHU = high 32 bits.
  - 12-15 are illegal: 1-cycle, result 0.
- Arithmetic: ADD/SUB wrap modulo 2^32, no overflow flag.
- States:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - DONE: result held.
- in_ready = (state==IDLE) or (state==DONE and out_ready). It is 0 throughout BUSY.
- Accept = in_valid & in_ready at a rising edge.
- Non-multiply accept at edge N: result, rd and Zero are registered at edge N; state=DONE; out_valid=1 in the cycle after edge N (latency 1).
- Multiply accept at edge N (MUL_ENABLE=1):
  - Operands and op are latched at edge N; 64-bit accumulator=0; counter=0; state=BUSY.
  - Each edge N+1..N+32 processes one multiplier bit, LSB first: if bit set, add the shifted multiplicand; counter increments.
  - At edge N+32: result selected (low or high half), state=DONE, out_valid=1. Latency is 33 cycles.
- DONE handling:
  - Outputs hold stable while out_ready=0 (backpressure). No field may change while out_valid=1 and out_ready=0.
  - out_ready=1 with no new accept: state=IDLE, out_valid=0 next cycle, ALU_result holds its last value.
  - out_ready=1 with a simultaneous accept: result consumed and new op accepted on the same edge. A non-multiply op gives out_valid=1 in the next cycle (back-to-back throughput of 1 op/cycle). A MUL op gives state=BUSY and out_valid=0.
- Input changes while in_ready=0 are ignored. A multiply in flight uses only its latched operands.
- Zero is recomputed on every registered result update.
- Reset mid-BUSY or mid-DONE: immediate return to the reset values; the in-flight operation is discarded and no out_valid pulse occurs.
- MUL_ENABLE=0: ops 10/11 behave as 1-cycle ops with result 0.

Test Plan:
- Reset then ADD, Read1=0x0000_0005, Read2=0xFFFF_FFFB, rd_in=3 -> next cycle out_valid=1, ALU_result=0, Zero=1, rd_out=3.
- SRA, Read1=0x8000_0000, Read2=0x0000_0024 (shift 4) -> ALU_result=0xF800_0000. SLT with 0xFFFF_FFFF vs 1 -> 1. SLTU with the same operands -> 0.
- MUL, 0xFFFF_FFFF x 2 -> in_ready=0 for 32 cycles; out_valid rises 33 cycles after accept; ALU_result=0xFFFF_FFFE. Repeat as MULHU -> 0x0000_0001.
- Hold out_ready=0 for 5 cycles after an OR result (0x0F0F_0000 | 0x0000_F0F0) -> ALU_result stays 0x0F0F_F0F0; in_ready=0; new inputs ignored. Then release -> accepted.
- Back-to-back stream of ADD, SUB, XOR with in_valid=out_ready=1 -> one result per cycle, in order, rd tags preserved.
- Assert rst at cycle 10 of a MUL -> out_valid=0, ALU_result=0, Zero=1 immediately. After release, a new ADD completes normally in 1 cycle.
